// File: rtl/vga_rx.sv
// vga_rx: VGA sink. Registers the raw RGB/hsync/vsync pins, rebuilds the
// horizontal/vertical counters from the sync leading edges, checks line and
// frame timing, locks after one clean frame and emits coordinate-tagged
// pixels while locked.
// Optional frame checksum: define VGA_RX_FRAME_CRC_EN to build a CRC-16-CCITT
// over every emitted pixel of a frame; otherwise frame_crc is tied to 0.
module vga_rx #(
    parameter int R               = 4,
    parameter int G               = 4,
    parameter int B               = 4,
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R-1:0]     vga_red,
    input  logic [G-1:0]     vga_green,
    input  logic [B-1:0]     vga_blue,
    input  logic             vga_hsync,
    input  logic             vga_vsync,
    output logic             pix_valid,
    output logic [10:0]      pix_x,
    output logic [9:0]       pix_y,
    output logic [R+G+B-1:0] pix_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err,
    output logic [7:0]       err_count,
    output logic [15:0]      frame_crc
);
    localparam int DW      = R + G + B;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] X_LAST  = 11'(H_VISIBLE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_VISIBLE - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ALIGN    = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t         state;
    logic           clean;      // no error seen since the current ALIGN frame began

    // input stage, syncs normalised to active-high
    logic [DW-1:0]  data_r;
    logic           hs_r, vs_r;
    logic           hs_d, vs_d;

    // counters hold the position of the previous input-stage sample
    logic [10:0]    hcnt;
    logic [9:0]     vcnt;

    logic           hs_edge, vs_edge;
    logic [10:0]    hcnt_n;
    logic [9:0]     vcnt_n;
    logic           line_err, frame_err, err;
    logic           lock_n;
    logic           vis;
    logic [10:0]    x_n;
    logic [9:0]     y_n;
    logic           emit;
    logic           done_n;

    // Register every pin once; the previous sync sample gives edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
            hs_r   <= 1'b0;
            vs_r   <= 1'b0;
            hs_d   <= 1'b0;
            vs_d   <= 1'b0;
        end else begin
            data_r <= {vga_red, vga_green, vga_blue};
            hs_r   <= (SYNC_ACTIVE_LOW != 0) ? ~vga_hsync : vga_hsync;
            vs_r   <= (SYNC_ACTIVE_LOW != 0) ? ~vga_vsync : vga_vsync;
            hs_d   <= hs_r;
            vs_d   <= vs_r;
        end
    end

    // Position of the sample now in the input stage, timing errors and the
    // decision whether the block is locked after this cycle.
    always_comb begin
        hs_edge = hs_r & ~hs_d;
        vs_edge = vs_r & ~vs_d;

        if (hs_edge)
            hcnt_n = '0;
        else if (hcnt == H_TOT)
            hcnt_n = H_TOT;
        else
            hcnt_n = hcnt + 11'd1;

        // vsync edge wins over a coincident hsync edge
        if (vs_edge)
            vcnt_n = '0;
        else if (hs_edge)
            vcnt_n = vcnt + 10'd1;
        else
            vcnt_n = vcnt;

        // bad line length at an hsync edge, or the count running into
        // H_TOTAL because the hsync never came
        line_err  = hs_edge ? (hcnt != H_LAST) : (hcnt == H_LAST);
        // vcnt counts the hsync edges since the last vsync edge, excluding
        // the one arriving together with this vsync edge
        frame_err = vs_edge && (({1'b0, vcnt} + 11'(hs_edge)) != V_TOT);
        err       = line_err | frame_err;

        lock_n = ((state == LOCKED) && !err) ||
                 ((state == ALIGN) && vs_edge && clean && !err);

        vis = (hcnt_n >= H_START) && (hcnt_n < H_END) &&
              (vcnt_n >= V_START) && (vcnt_n < V_END);
        x_n = hcnt_n - H_START;
        y_n = vcnt_n - V_START;

        emit   = lock_n && vis;
        done_n = lock_n && pix_valid && (pix_x == X_LAST) && (pix_y == Y_LAST);
    end

    // Counters, lock FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            state       <= UNLOCKED;
            clean       <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            hcnt <= hcnt_n;
            vcnt <= vcnt_n;

            case (state)
                // errors are ignored until the first frame boundary is seen
                UNLOCKED: begin
                    if (vs_edge) begin
                        state <= ALIGN;
                        clean <= 1'b1;
                    end
                end
                // a new attempt starts at every vsync edge; errors at that
                // edge belong to the frame that just ended
                ALIGN: begin
                    if (vs_edge && clean && !err)
                        state <= LOCKED;
                    if (vs_edge)
                        clean <= 1'b1;
                    else if (err)
                        clean <= 1'b0;
                end
                // losing lock mid-frame needs a full frame from the next
                // vsync edge; losing it at a vsync edge can use the frame
                // that starts right there
                LOCKED: begin
                    if (err) begin
                        state <= ALIGN;
                        clean <= vs_edge;
                    end
                end
                default: begin
                    state <= UNLOCKED;
                    clean <= 1'b0;
                end
            endcase

            locked   <= lock_n;
            sync_err <= (state == LOCKED) && err;
            if ((state == LOCKED) && err && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;

            pix_valid <= emit;
            if (emit) begin
                pix_x    <= x_n;
                pix_y    <= y_n;
                pix_data <= data_r;
            end
            frame_start <= emit && (x_n == '0) && (y_n == '0);
            frame_done  <= done_n;
        end
    end

`ifdef VGA_RX_FRAME_CRC_EN
    // CRC-16-CCITT, polynomial 0x1021, one pixel word per call, MSB first
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [DW-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = DW - 1; i >= 0; i--) begin
            if (r[15] ^ d[i])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_run;

    // Running CRC restarts at pixel (0,0); only a completed frame publishes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_run   <= '0;
            frame_crc <= '0;
        end else begin
            if (emit)
                crc_run <= crc_step(((x_n == '0) && (y_n == '0)) ? 16'hFFFF : crc_run, data_r);
            if (done_n)
                frame_crc <= crc_run;
        end
    end
`else
    assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed bench for vga_rx on a small raster (10x8 totals).
// Two instances see the same stream, one with active-low syncs and one with
// active-high syncs driven inverted; both are held to the same expectations.
module tb_vga_rx;
    localparam int HV = 6, HF = 1, HS = 2, HB = 1;
    localparam int VV = 4, VF = 2, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  red, green, blue;
    logic        hs_n, vs_n, hs_p, vs_p;

    logic        a_pix_valid, b_pix_valid;
    logic [10:0] a_pix_x, b_pix_x;
    logic [9:0]  a_pix_y, b_pix_y;
    logic [11:0] a_pix_data, b_pix_data;
    logic        a_frame_start, b_frame_start, a_frame_done, b_frame_done;
    logic        a_locked, b_locked, a_sync_err, b_sync_err;
    logic [7:0]  a_err_count, b_err_count;
    logic [15:0] a_frame_crc, b_frame_crc;

    always #5 clk = ~clk;

    vga_rx #(.R(4), .G(4), .B(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
             .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .vga_red(red), .vga_green(green), .vga_blue(blue),
        .vga_hsync(hs_n), .vga_vsync(vs_n),
        .pix_valid(a_pix_valid), .pix_x(a_pix_x), .pix_y(a_pix_y), .pix_data(a_pix_data),
        .frame_start(a_frame_start), .frame_done(a_frame_done), .locked(a_locked),
        .sync_err(a_sync_err), .err_count(a_err_count), .frame_crc(a_frame_crc));

    vga_rx #(.R(4), .G(4), .B(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
             .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .vga_red(red), .vga_green(green), .vga_blue(blue),
        .vga_hsync(hs_p), .vga_vsync(vs_p),
        .pix_valid(b_pix_valid), .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_data(b_pix_data),
        .frame_start(b_frame_start), .frame_done(b_frame_done), .locked(b_locked),
        .sync_err(b_sync_err), .err_count(b_err_count), .frame_crc(b_frame_crc));

    typedef struct packed {
        logic        zero;   // outputs expected all-zero (reset)
        logic        vld;
        logic [10:0] x;
        logic [9:0]  y;
        logic [11:0] d;
    } exp_t;

    int          n_chk = 0, n_err = 0;
    exp_t        e1, e2, ez;
    logic [10:0] hx;
    logic [9:0]  hy;
    logic [11:0] hd;
    logic        last_px;
    int          mode;
    int          pv_cnt, fd_cnt, se_a, se_b;
    logic [15:0] exp_crc;
`ifdef VGA_RX_FRAME_CRC_EN
    logic [15:0] crc_acc;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // check outputs against the sample driven two cycles ago, then drive one cycle
    task automatic step(input logic hs, input logic vs, input logic [11:0] d,
                        input exp_t cur, input logic r);
        logic ld;
        if (e2.zero) begin
            hx = '0; hy = '0; hd = '0;
        end else if (e2.vld) begin
            hx = e2.x; hy = e2.y; hd = e2.d;
        end
        ld = !e2.zero && e2.vld && (e2.x == 11'(HV - 1)) && (e2.y == 10'(VV - 1));
        chk("a_pix_valid", a_pix_valid, e2.vld);
        chk("a_pix_x", a_pix_x, hx);
        chk("a_pix_y", a_pix_y, hy);
        chk("a_pix_data", a_pix_data, hd);
        chk("a_frame_start", a_frame_start, e2.vld && e2.x == 0 && e2.y == 0);
        chk("a_frame_done", a_frame_done, last_px);
        chk("b_pix_valid", b_pix_valid, e2.vld);
        chk("b_pix_xy", {b_pix_x, b_pix_y}, {hx, hy});
        chk("b_pix_data", b_pix_data, hd);
        chk("b_frame_start", b_frame_start, e2.vld && e2.x == 0 && e2.y == 0);
        chk("b_frame_done", b_frame_done, last_px);
        last_px = ld;
        if (a_pix_valid) pv_cnt++;
        if (a_frame_done) fd_cnt++;
        if (a_sync_err) se_a++;
        if (b_sync_err) se_b++;
        if (r) begin
            e1 = ez; e2 = ez; exp_crc = '0; last_px = 1'b0;
        end else begin
            e2 = e1; e1 = cur;
        end
        rst = r;
        {red, green, blue} = d;
        hs_n = ~hs; vs_n = ~vs; hs_p = hs; vs_p = vs;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one frame: optional 1-clock-long line, optional reset point (line, col)
    task automatic frame(input int nlines, input int long_ln, input bit emit,
                         input int rst_ln, input int rst_col);
        bit on;
        on = emit;
        pv_cnt = 0; fd_cnt = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < ((l == long_ln) ? HT + 1 : HT); c++) begin
                exp_t        cur;
                logic [11:0] d;
                int          x, y;
                bit          vis;
                x = c - (HS + HB);
                y = l - (VS + VB);
                vis = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
                d = (mode == 0) ? 12'hFFF : {x[3:0], y[3:0], x[7:4]};
                cur = '0;
                cur.vld = on && vis;
                cur.x = 11'(x);
                cur.y = 10'(y);
                cur.d = d;
`ifdef VGA_RX_FRAME_CRC_EN
                if (cur.vld) crc_acc = crc16((x == 0 && y == 0) ? 16'hFFFF : crc_acc, d);
`endif
                if (l == rst_ln && c == rst_col) begin
                    step(c < HS, l < VS, d, cur, 1'b1);
                    on = 0;
                end else begin
                    step(c < HS, l < VS, d, cur, 1'b0);
                end
            end
            if (l == long_ln) on = 0;
        end
`ifdef VGA_RX_FRAME_CRC_EN
        if (emit && long_ln < 0 && rst_ln < 0) exp_crc = crc_acc;
`endif
        chk("a_frame_crc", a_frame_crc, exp_crc);
        chk("b_frame_crc", b_frame_crc, exp_crc);
    endtask

    initial begin
        logic [15:0] crc_fff;
        ez = '0; ez.zero = 1'b1;
        e1 = ez; e2 = ez;
        hx = '0; hy = '0; hd = '0; last_px = 1'b0;
        mode = 0; pv_cnt = 0; fd_cnt = 0; se_a = 0; se_b = 0; exp_crc = '0;
`ifdef VGA_RX_FRAME_CRC_EN
        crc_acc = '0;
`endif
        crc_fff = 16'hFFFF;
        for (int i = 0; i < HV * VV; i++) crc_fff = crc16(crc_fff, 12'hFFF);
        rst = 1'b1;
        {red, green, blue} = '0;
        hs_n = 1'b1; vs_n = 1'b1; hs_p = 1'b0; vs_p = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_locked", a_locked, 0);
        chk("rst_err_count", a_err_count, 0);
        chk("rst_pix_valid", a_pix_valid, 0);
        chk("rst_frame_crc", a_frame_crc, 0);
        repeat (5) step(1'b0, 1'b0, 12'h000, '0, 1'b0);

        // clean stream, constant 0xFFF: lock at the second vsync edge
        frame(VT, -1, 0, -1, -1);
        chk("f0_locked", a_locked, 0);
        chk("f0_pixels", pv_cnt, 0);
        frame(VT, -1, 1, -1, -1);
        chk("f1_locked", a_locked, 1);
        chk("f1_b_locked", b_locked, 1);
        chk("f1_pixels", pv_cnt, HV * VV);
        chk("f1_done", fd_cnt, 1);
`ifdef VGA_RX_FRAME_CRC_EN
        chk("f1_crc_ref", a_frame_crc, crc_fff);
`endif
        frame(VT, -1, 1, -1, -1);
`ifdef VGA_RX_FRAME_CRC_EN
        chk("f2_crc_ref", a_frame_crc, crc_fff);
`endif
        chk("clean_sync_err", se_a + se_b, 0);

        // coordinate pattern
        mode = 1;
        frame(VT, -1, 1, -1, -1);
        chk("pat_pixels", pv_cnt, HV * VV);
        frame(VT, -1, 1, -1, -1);

        // one long line on visible row 1 while locked
        frame(VT, VS + VB + 1, 1, -1, -1);
        chk("long_sync_err", se_a, 1);
        chk("long_err_count", a_err_count, 1);
        chk("long_b_err_count", b_err_count, 1);
        chk("long_locked", a_locked, 0);
        chk("long_pixels", pv_cnt, 2 * HV);
        frame(VT, -1, 0, -1, -1);
        chk("long_align", a_locked, 0);
        frame(VT, -1, 1, -1, -1);
        chk("long_relock", a_locked, 1);

        // short frame: error seen at the following vsync edge
        frame(VT - 1, -1, 1, -1, -1);
        chk("short_pixels", pv_cnt, HV * VV);
        chk("short_no_err_yet", se_a, 1);
        frame(VT, -1, 0, -1, -1);
        chk("short_sync_err", se_a, 2);
        chk("short_err_count", a_err_count, 2);
        chk("short_locked", a_locked, 0);
        frame(VT, -1, 1, -1, -1);
        chk("short_relock", a_locked, 1);

        // repeated short frames until err_count saturates
        for (int i = 0; i < 256; i++) begin
            frame(VT - 1, -1, 1, -1, -1);
            frame(VT, -1, 0, -1, -1);
            if (i == 99) chk("sat_mid", a_err_count, 102);
        end
        chk("sat_a", a_err_count, 255);
        chk("sat_b", b_err_count, 255);
        frame(VT, -1, 1, -1, -1);
        chk("sat_relock", a_locked, 1);

        // reset mid-frame at pixel (3,2)
        frame(VT, -1, 1, VS + VB + 2, HS + HB + 3);
        chk("mid_rst_locked", a_locked, 0);
        chk("mid_rst_err_count", a_err_count, 0);
        chk("mid_rst_b_err_count", b_err_count, 0);
        frame(VT, -1, 0, -1, -1);
        chk("mid_rst_align", a_locked, 0);
        frame(VT, -1, 1, -1, -1);
        chk("mid_rst_relock", a_locked, 1);
        chk("mid_rst_pixels", pv_cnt, HV * VV);
        chk("pol_sync_err", se_b, se_a);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
